// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the PC trace capture block
// Purpose: capture FSM state encoding, FIFO entry layout and the PC reset value.
// Ports: none (package).
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  // Entry layout matches traceData: pc in [63:32], alu in [31:0].
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
  } trace_entry_t;

  // Impossible as a live PC, so PC 0 right after reset counts as a new instruction.
  localparam logic [31:0] PC_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/pc_trace_capture_if.sv
// rtl/pc_trace_capture_if.sv - valid/ready stream carrying captured trace entries
// Purpose: bundles the host-side drain stream of the trace capture block.
// Ports (signals): traceData[63:0] {pc, alu} at FIFO head, traceValid head present,
//   traceReady reader accepts head. master = capture block, slave = reader.
interface pc_trace_capture_if;
  logic [63:0] traceData;
  logic        traceValid;
  logic        traceReady;

  modport master (output traceData, output traceValid, input traceReady);
  modport slave  (input traceData, input traceValid, output traceReady);
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - DEPTH x 64 trace FIFO with pop-and-push-when-full support
// Purpose: stores captured entries; a push into a full FIFO is accepted only if the
//   head is popped in the same cycle, otherwise it is reported as dropped.
// Ports: clk, resetN (async active-low), pushValid/pushData write side,
//   popReady read accept, headData/headValid head of queue, full, pushDropped.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         pushValid,
  input  trace_entry_t pushData,
  input  logic         popReady,
  output trace_entry_t headData,
  output logic         headValid,
  output logic         full,
  output logic         pushDropped
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty when the indices match.
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  trace_entry_t mem [DEPTH];
  logic         empty;
  logic         pop;
  logic         pushAccept;

  assign empty       = (wrPtr == rdPtr);
  assign full        = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop         = popReady && !empty;
  assign pushAccept  = pushValid && (!full || pop);
  assign pushDropped = pushValid && full && !pop;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushAccept) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)        rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // When full, the write slot equals the slot being popped; the old value is read
  // out this cycle and overwritten at the same edge.
  always_ff @(posedge clk) begin
    if (pushAccept) mem[wrPtr[AW-1:0]] <= pushData;
  end

  // Gated by empty so the head reads as zero after reset and after draining.
  assign headValid = !empty;
  assign headData  = empty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/pc_trace_capture.sv
// rtl/pc_trace_capture.sv - armed/triggered PC+ALU trace capture into a drain FIFO
// Purpose: watches the core PC, and once armed and triggered records one {pc, alu}
//   entry per new instruction; never back-pressures the core.
// Ports: clk, resetN (async active-low), programCounter/aluResult core taps,
//   arm pulse, triggerPc, captureLen (0 = unlimited), traceBus stream (master),
//   capturing, done, overflow (sticky), dropCount (saturating).
module pc_trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 8,
  parameter int DROP_W = 16
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [31:0]         programCounter,
  input  logic [31:0]         aluResult,
  input  logic                arm,
  input  logic [31:0]         triggerPc,
  input  logic [LEN_W-1:0]    captureLen,
  pc_trace_capture_if.master  traceBus,
  output logic                capturing,
  output logic                done,
  output logic                overflow,
  output logic [DROP_W-1:0]   dropCount
);

  state_t           state;
  state_t           nextState;
  logic [31:0]      prevPc;
  logic [LEN_W-1:0] capturedCnt;
  logic [LEN_W-1:0] capturedNext;
  logic             newInstr;
  logic             push;
  logic             clearFlags;
  logic             loadCnt;
  logic             incCnt;
  logic             pushDropped;
  logic             fifoFull;
  trace_entry_t     pushData;
  trace_entry_t     headData;

  assign newInstr     = (programCounter != prevPc);
  assign capturedNext = capturedCnt + LEN_W'(1);
  assign pushData     = '{pc: programCounter, alu: aluResult};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      prevPc <= PC_RESET;
    end else begin
      state  <= nextState;
      prevPc <= programCounter;
    end
  end

  always_comb begin
    nextState  = state;
    push       = 1'b0;
    clearFlags = 1'b0;
    loadCnt    = 1'b0;
    incCnt     = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          nextState  = ARMED;
          clearFlags = 1'b1;
        end
      end
      ARMED: begin
        // The trigger instruction itself is the first entry, so a length of 1 ends here.
        if (newInstr && (programCounter == triggerPc)) begin
          push      = 1'b1;
          loadCnt   = 1'b1;
          nextState = (captureLen == LEN_W'(1)) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (newInstr) begin
          push   = 1'b1;
          incCnt = 1'b1;
          if ((captureLen != '0) && (capturedNext == captureLen)) nextState = DONE;
        end
      end
      DONE: begin
        if (arm) begin
          nextState  = ARMED;
          clearFlags = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      capturedCnt <= '0;
      overflow    <= 1'b0;
      dropCount   <= '0;
    end else begin
      if (clearFlags) begin
        capturedCnt <= '0;
        overflow    <= 1'b0;
        dropCount   <= '0;
      end else begin
        if (loadCnt)     capturedCnt <= LEN_W'(1);
        else if (incCnt) capturedCnt <= capturedNext;
        if (pushDropped) begin
          overflow <= 1'b1;
          if (dropCount != '1) dropCount <= dropCount + DROP_W'(1);
        end
      end
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk        (clk),
    .resetN     (resetN),
    .pushValid  (push),
    .pushData   (pushData),
    .popReady   (traceBus.traceReady),
    .headData   (headData),
    .headValid  (traceBus.traceValid),
    .full       (fifoFull),
    .pushDropped(pushDropped)
  );

  assign traceBus.traceData = headData;
  assign capturing = (state == CAPTURE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_pc_trace_capture.sv
// tb/tb_pc_trace_capture.sv - directed scoreboard bench for pc_trace_capture
module tb_pc_trace_capture;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] pc;
  logic [31:0] alu;
  logic        arm;
  logic [31:0] triggerPc;
  logic [7:0]  captureLen;
  logic        capturing;
  logic        done;
  logic        overflow;
  logic [15:0] dropCount;

  pc_trace_capture_if tif ();

  pc_trace_capture #(.DEPTH(4), .LEN_W(8), .DROP_W(16)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .programCounter(pc),
    .aluResult     (alu),
    .arm           (arm),
    .triggerPc     (triggerPc),
    .captureLen    (captureLen),
    .traceBus      (tif.master),
    .capturing     (capturing),
    .done          (done),
    .overflow      (overflow),
    .dropCount     (dropCount)
  );

  always #5 clk = ~clk;

  int          nVec = 0;
  int          nErr = 0;
  int          popCount = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs already driven: if the head will be
  // accepted at the coming posedge, score it against the oldest expected entry.
  task automatic cyc();
    logic [63:0] exp;
    if (tif.traceValid && tif.traceReady) begin
      popCount++;
      nVec++;
      assert (sb.size() != 0) else begin
        nErr++;
        $error("FAIL unexpectedEntry observed=%0h expected=none", tif.traceData);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("entry", tif.traceData, exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] a);
    pc  = p;
    alu = a;
  endtask

  initial begin
    int p0;
    resetN = 1'b0; pc = 32'h0; alu = 32'h0; arm = 1'b0;
    triggerPc = 32'h0; captureLen = 8'd0; tif.traceReady = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rstValid", 64'(tif.traceValid), 64'd0);
    chk("rstData", tif.traceData, 64'd0);
    chk("rstFlags", {60'd0, capturing, done, overflow, 1'b0}, 64'd0);
    chk("rstDrop", 64'(dropCount), 64'd0);
    resetN = 1'b1;
    @(negedge clk);

    // Full FIFO with a pop and a push in the same cycle: no drop.
    arm = 1'b1; triggerPc = 32'h60; captureLen = 8'd0; drive(32'h5C, 32'h0); cyc();
    arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h60 + 32'(4*i), 32'h1060 + 32'(4*i));
      sb.push_back({pc, alu});
      cyc();
    end
    chk("fullValid", 64'(tif.traceValid), 64'd1);
    chk("fullCapturing", 64'(capturing), 64'd1);
    tif.traceReady = 1'b1; drive(32'h70, 32'h1070); sb.push_back({pc, alu}); cyc();
    tif.traceReady = 1'b0; cyc();
    chk("popPushOverflow", 64'(overflow), 64'd0);
    chk("popPushDrop", 64'(dropCount), 64'd0);
    p0 = popCount;
    tif.traceReady = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("popPushOccupancy", 64'(popCount - p0), 64'd4);
    chk("drainedValid", 64'(tif.traceValid), 64'd0);

    // PC held for 5 cycles: one entry only, with the first cycle's alu.
    p0 = popCount;
    for (int i = 0; i < 5; i++) begin
      drive(32'h20, 32'hAAAA_0000 + 32'(i));
      if (i == 0) sb.push_back({pc, alu});
      cyc();
    end
    for (int i = 0; i < 3; i++) cyc();
    chk("heldPcEntries", 64'(popCount - p0), 64'd1);

    // Overflow during unlimited capture, then an ignored arm in CAPTURE.
    tif.traceReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h80 + 32'(4*i), 32'h80);
      cyc();
    end
    chk("ovfCapture", 64'(overflow), 64'd1);
    chk("dropCapture", 64'(dropCount), 64'd1);
    arm = 1'b1; cyc(); arm = 1'b0;
    chk("armIgnoredCapturing", 64'(capturing), 64'd1);
    chk("armIgnoredOvf", 64'(overflow), 64'd1);
    chk("armIgnoredDrop", 64'(dropCount), 64'd1);

    // Asynchronous reset mid-capture clears everything without a clock edge.
    #2 resetN = 1'b0;
    #1;
    chk("asyncValid", 64'(tif.traceValid), 64'd0);
    chk("asyncData", tif.traceData, 64'd0);
    chk("asyncFlags", {60'd0, capturing, done, overflow, 1'b0}, 64'd0);
    chk("asyncDrop", 64'(dropCount), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    triggerPc = 32'h100;
    for (int i = 0; i < 6; i++) begin
      drive(32'h100 + 32'(4*i), 32'h1);
      cyc();
      chk("idleNoValid", 64'(tif.traceValid), 64'd0);
    end

    // Triggered capture of 3 with the reader always ready.
    tif.traceReady = 1'b1; triggerPc = 32'h8; captureLen = 8'd3;
    arm = 1'b1; drive(32'h0, 32'h1); cyc(); arm = 1'b0;
    for (int i = 1; i < 6; i++) begin
      drive(32'(4*i), 32'(4*i) + 32'h1);
      if (i >= 2 && i <= 4) sb.push_back({pc, alu});
      cyc();
      if (i == 4) chk("doneAfterLast", 64'(done), 64'd1);
    end
    for (int i = 0; i < 4; i++) cyc();
    chk("len3Drained", 64'(sb.size()), 64'd0);

    // Capture of 6 into a 4-deep FIFO with no reader: 4 kept, 2 dropped.
    tif.traceReady = 1'b0; triggerPc = 32'h40; captureLen = 8'd6;
    arm = 1'b1; drive(32'h30, 32'h0); cyc(); arm = 1'b0;
    chk("rearmDoneCleared", 64'(done), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive(32'h40 + 32'(4*i), 32'hA5A5_0000 ^ (32'h40 + 32'(4*i)));
      if (i < 4) sb.push_back({pc, alu});
      cyc();
    end
    chk("ovfDone", 64'(done), 64'd1);
    chk("ovfSet", 64'(overflow), 64'd1);
    chk("ovfDropCount", 64'(dropCount), 64'd2);

    // arm in DONE clears flags but the FIFO keeps its entries and drains.
    arm = 1'b1; cyc(); arm = 1'b0;
    chk("armDoneOvf", 64'(overflow), 64'd0);
    chk("armDoneDrop", 64'(dropCount), 64'd0);
    chk("armDoneState", {62'd0, capturing, done}, 64'd0);
    chk("armDoneValid", 64'(tif.traceValid), 64'd1);
    p0 = popCount;
    tif.traceReady = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    for (int i = 0; i < 3; i++) cyc();
    chk("drainCount", 64'(popCount - p0), 64'd4);
    chk("drainEmpty", 64'(sb.size()), 64'd0);
    chk("drainValid", 64'(tif.traceValid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
